// File: rtl/wave_bank_scheduler.sv
// Display-side bank scheduler for the two-bank wave RAM: per-frame bank pinning, post-vsync swap window, sample/prev fetch (WAVE_FREEZE_EN adds freeze).
// Latency: response 4 cycles after accept; swap window of SWAP_CYCLES cycles starts the cycle after a vsync rise.
// Backpressure: req_ready drops while a fetch is in flight, a swap is pending, or the swap/latch sequence runs.
module wave_bank_scheduler #(
    parameter int SWAP_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vsync,
    input  logic       read_index,
`ifdef WAVE_FREEZE_EN
    input  logic       freeze,
`endif
    input  logic       req_valid,
    input  logic [7:0] req_index,
    output logic       req_ready,
    output logic [8:0] ram_raddr,
    input  logic [7:0] ram_rdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_sample,
    output logic [7:0] rsp_prev_sample,
    output logic       wave_display_idle,
    output logic       frame_bank
);

    typedef enum logic [1:0] {DRAW, SWAP, LATCH} state_t;

    localparam logic [7:0] SWAP_LOAD = 8'(SWAP_CYCLES - 1);

    state_t     state;
    logic       vsync_prev;
    logic [7:0] swap_cnt;
    logic [2:0] stage;
    logic       pending;
    logic [7:0] idx_q;
    logic       rise;
    logic       accept;

`ifdef WAVE_FREEZE_EN
    assign rise = vsync && !vsync_prev && !freeze;
`else
    assign rise = vsync && !vsync_prev;
`endif
    assign accept = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= DRAW;
            vsync_prev        <= 1'b0;
            swap_cnt          <= 8'd0;
            stage             <= 3'd0;
            pending           <= 1'b0;
            idx_q             <= 8'd0;
            req_ready         <= 1'b0;
            ram_raddr         <= 9'd0;
            rsp_valid         <= 1'b0;
            rsp_sample        <= 8'd0;
            rsp_prev_sample   <= 8'd0;
            wave_display_idle <= 1'b0;
            frame_bank        <= 1'b0;
        end else begin
            vsync_prev <= vsync;
            rsp_valid  <= 1'b0;
            case (state)
                DRAW: begin
                    wave_display_idle <= 1'b0;
                    if (accept) begin
                        idx_q     <= req_index;
                        ram_raddr <= {frame_bank, req_index};
                        stage     <= 3'd1;
                        req_ready <= 1'b0;
                        if (rise) pending <= 1'b1;
                    end else if (stage != 3'd0) begin
                        // A rise during a fetch is deferred until the response has gone out.
                        if (rise) pending <= 1'b1;
                        req_ready <= 1'b0;
                        case (stage)
                            3'd1: begin
                                ram_raddr <= {frame_bank, (idx_q == 8'd0) ? 8'd0 : idx_q - 8'd1};
                                stage     <= 3'd2;
                            end
                            3'd2: begin
                                rsp_sample <= ram_rdata;
                                stage      <= 3'd3;
                            end
                            3'd3: begin
                                rsp_prev_sample <= ram_rdata;
                                stage           <= 3'd4;
                            end
                            default: begin
                                rsp_valid <= 1'b1;
                                stage     <= 3'd0;
                            end
                        endcase
                    end else if (pending || rise) begin
                        state             <= SWAP;
                        swap_cnt          <= SWAP_LOAD;
                        wave_display_idle <= 1'b1;
                        pending           <= 1'b0;
                        req_ready         <= 1'b0;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                SWAP: begin
                    req_ready <= 1'b0;
                    if (swap_cnt == 8'd0) begin
                        state             <= LATCH;
                        wave_display_idle <= 1'b0;
                    end else begin
                        swap_cnt <= swap_cnt - 8'd1;
                    end
                end
                LATCH: begin
                    req_ready  <= 1'b0;
                    frame_bank <= read_index;
                    state      <= DRAW;
                end
                default: state <= DRAW;
            endcase
        end
    end

endmodule

// File: tb/tb_wave_bank_scheduler.sv
// Randomized bench for wave_bank_scheduler against a timeline reference model (accept/swap timestamps).
module tb_wave_bank_scheduler;

    localparam int SC = 4;
    localparam int NCYC = 4000;

    logic       clk = 1'b0;
    logic       reset;
    logic       vsync;
    logic       read_index;
    logic       freeze;
    logic       req_valid;
    logic [7:0] req_index;
    logic       req_ready;
    logic [8:0] ram_raddr;
    logic [7:0] ram_rdata;
    logic       rsp_valid;
    logic [7:0] rsp_sample;
    logic [7:0] rsp_prev_sample;
    logic       wave_display_idle;
    logic       frame_bank;

    logic [7:0] mem [512];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) ram_rdata <= mem[ram_raddr];

    wave_bank_scheduler #(.SWAP_CYCLES(SC)) dut (
        .clk               (clk),
        .reset             (reset),
        .vsync             (vsync),
        .read_index        (read_index),
`ifdef WAVE_FREEZE_EN
        .freeze            (freeze),
`endif
        .req_valid         (req_valid),
        .req_index         (req_index),
        .req_ready         (req_ready),
        .ram_raddr         (ram_raddr),
        .ram_rdata         (ram_rdata),
        .rsp_valid         (rsp_valid),
        .rsp_sample        (rsp_sample),
        .rsp_prev_sample   (rsp_prev_sample),
        .wave_display_idle (wave_display_idle),
        .frame_bank        (frame_bank)
    );

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
        end
    endtask

    // Reference model: last accept edge a, last swap-window start edge r.
    int         a, r;
    logic       m_ready, m_vs_prev, m_fb, rise;
    logic [8:0] m_raddr, addr0, addr1;
    logic [7:0] m_sample, m_prev;
    int         vs_hold, frz_hold;

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
        reset = 1'b1; vsync = 1'b0; read_index = 1'b0; freeze = 1'b0;
        req_valid = 1'b0; req_index = 8'd0;
        vs_hold = 5; frz_hold = 100;
        a = -100; r = -100; addr0 = 9'd0; addr1 = 9'd0;

        for (int n = 0; n < NCYC; n++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (reset) begin
                a = -100; r = -100; m_ready = 1'b0; m_vs_prev = 1'b0; m_fb = 1'b0;
                m_raddr = 9'd0; m_sample = 8'd0; m_prev = 8'd0;
            end else begin
                rise = vsync && !m_vs_prev;
`ifdef WAVE_FREEZE_EN
                if (freeze) rise = 1'b0;
`endif
                m_vs_prev = vsync;
                if (req_valid && m_ready) begin
                    a = cyc;
                    addr0 = {m_fb, req_index};
                    addr1 = {m_fb, (req_index == 8'd0) ? 8'd0 : req_index - 8'd1};
                    m_raddr = addr0;
                end else if (cyc == a + 1) begin
                    m_raddr = addr1;
                end
                if (cyc == a + 2) m_sample = mem[addr0];
                if (cyc == a + 3) m_prev = mem[addr1];
                if (rise && !(cyc >= r && cyc <= r + SC + 1))
                    r = (cyc >= a && cyc <= a + 4) ? a + 5 : cyc;
                if (cyc == r + SC + 1) m_fb = read_index;
                m_ready = !(cyc >= a && cyc <= a + 4) && !(cyc >= r && cyc <= r + SC + 1);
            end

            chk("req_ready", {8'd0, req_ready}, {8'd0, m_ready});
            chk("rsp_valid", {8'd0, rsp_valid}, {8'd0, (!reset && cyc == a + 4)});
            chk("idle", {8'd0, wave_display_idle}, {8'd0, (!reset && cyc >= r && cyc <= r + SC - 1)});
            chk("frame_bank", {8'd0, frame_bank}, {8'd0, m_fb});
            chk("ram_raddr", ram_raddr, m_raddr);
            chk("rsp_sample", {1'b0, rsp_sample}, {1'b0, m_sample});
            chk("rsp_prev", {1'b0, rsp_prev_sample}, {1'b0, m_prev});

            // Next-edge stimulus.
            reset = (n < 3) || ($urandom_range(0, 249) == 0);
            if (--vs_hold <= 0) begin
                vsync = ~vsync;
                vs_hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 30);
            end
            if (--frz_hold <= 0) begin
                freeze = ~freeze;
                frz_hold = $urandom_range(20, 120);
            end
            if ($urandom_range(0, 7) == 0) read_index = ~read_index;
            req_valid = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 7))
                0: req_index = 8'd0;
                1: req_index = 8'd255;
                default: req_index = 8'($urandom);
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
